// File: rtl/light_dance_pkg.sv
// Shared definitions for the light dance controller: FSM state encoding
// and the four step-pattern mode encodings.
package light_dance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_FILL = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

endpackage

// File: rtl/ld_tick_div.sv
// Step-rate divider: counts enabled cycles and raises tick when the count
// equals period, then wraps to zero. clear holds the count at zero.
module ld_tick_div (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] period,
    output logic       tick
);

    logic [3:0] cnt_r;

    // Tick fires on the cycle whose count matches the period.
    always_comb begin
        tick = enable & (cnt_r == period);
    end

    // Divider count: cleared outside a run, wraps on every tick.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r <= 4'd0;
        end else if (clear) begin
            cnt_r <= 4'd0;
        end else if (enable) begin
            if (tick) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

endmodule

// File: rtl/light_dance_ctrl.sv
// LED dance controller: loads a pattern on start, then shifts it STEPS
// times at a programmable rate using one of four step patterns.
// Optional feature macro: LIGHT_DANCE_PINGPONG_EN (bouncing ping-pong in
// mode 11; without it mode 11 is a plain rotate-left).
module light_dance_ctrl
    import light_dance_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [3:0]       speed,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

    state_e           state_r;
    logic [WIDTH-1:0] leds_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       mode_r;
    logic [3:0]       speed_r;
    logic [7:0]       step_cnt_r;
    logic             tick_s;
    logic             div_clear_s;
    logic             div_en_s;
    logic [WIDTH-1:0] step_leds_s;
`ifdef LIGHT_DANCE_PINGPONG_EN
    logic             dir_r;      // 0 = moving left, 1 = moving right
    logic             step_dir_s;
`endif

    assign leds = leds_r;
    assign busy = busy_r;
    assign done = done_r;

    // Divider runs only in RUN; any other state keeps it parked at zero.
    always_comb begin
        div_clear_s = (state_r != ST_RUN);
        div_en_s    = (state_r == ST_RUN);
    end

    ld_tick_div u_tick_div (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (div_clear_s),
        .enable (div_en_s),
        .period (speed_r),
        .tick   (tick_s)
    );

    // Next LED value (and bounce direction) for one step of the latched mode.
    always_comb begin
        step_leds_s = leds_r;
`ifdef LIGHT_DANCE_PINGPONG_EN
        step_dir_s  = dir_r;
`endif
        case (mode_r)
            MODE_ROL:  step_leds_s = {leds_r[WIDTH-2:0], leds_r[WIDTH-1]};
            MODE_ROR:  step_leds_s = {leds_r[0], leds_r[WIDTH-1:1]};
            MODE_FILL: step_leds_s = {leds_r[WIDTH-2:0], 1'b1};
            MODE_PING: begin
`ifdef LIGHT_DANCE_PINGPONG_EN
                // Hitting an edge bit flips direction and steps back inward.
                if (!dir_r) begin
                    if (leds_r[WIDTH-1]) begin
                        step_dir_s  = 1'b1;
                        step_leds_s = leds_r >> 1;
                    end else begin
                        step_leds_s = leds_r << 1;
                    end
                end else begin
                    if (leds_r[0]) begin
                        step_dir_s  = 1'b0;
                        step_leds_s = leds_r << 1;
                    end else begin
                        step_leds_s = leds_r >> 1;
                    end
                end
`else
                step_leds_s = {leds_r[WIDTH-2:0], leds_r[WIDTH-1]};
`endif
            end
            default: step_leds_s = leds_r;
        endcase
    end

    // Main FSM with registered leds/busy/done and latched run settings.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= ST_IDLE;
            leds_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mode_r     <= 2'b00;
            speed_r    <= 4'd0;
            step_cnt_r <= 8'd0;
`ifdef LIGHT_DANCE_PINGPONG_EN
            dir_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !stop) begin
                        state_r    <= ST_RUN;
                        leds_r     <= pattern;
                        mode_r     <= mode;
                        speed_r    <= speed;
                        step_cnt_r <= 8'd0;
                        busy_r     <= 1'b1;
`ifdef LIGHT_DANCE_PINGPONG_EN
                        dir_r      <= 1'b0;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        leds_r  <= '0;
                        busy_r  <= 1'b0;
                    end else if (tick_s) begin
                        leds_r <= step_leds_s;
`ifdef LIGHT_DANCE_PINGPONG_EN
                        dir_r  <= step_dir_s;
`endif
                        if (step_cnt_r == LAST_STEP) begin
                            state_r    <= ST_DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            step_cnt_r <= 8'd0;
                        end else begin
                            step_cnt_r <= step_cnt_r + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_dance_ctrl.sv
// Self-checking bench for light_dance_ctrl (WIDTH=8, STEPS=16).
// A behavioural model precomputes each run's LED sequence arithmetically
// and derives busy/done from the elapsed cycle count.
module tb_light_dance_ctrl;

    localparam int W     = 8;
    localparam int STEPS = 16;

    logic         clk    = 1'b0;
    logic         arst_n = 1'b0;
    logic         start  = 1'b0;
    logic         stop   = 1'b0;
    logic [1:0]   mode   = 2'b00;
    logic [3:0]   speed  = 4'd0;
    logic [W-1:0] pattern = 8'h00;
    logic [W-1:0] leds;
    logic         busy;
    logic         done;
    bit           clk_en = 1'b1;

    int checks = 0;
    int errors = 0;

    light_dance_ctrl #(.WIDTH(W), .STEPS(STEPS)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .speed   (speed),
        .pattern (pattern),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
    );

    always #5 if (clk_en) clk = ~clk;

    // ---------------- reference model ----------------
    int m_phase = 0;          // 0 idle, 1 running, 2 done-pulse
    int m_n = 0;              // edges since the run-entry edge
    int m_p = 0;              // latched speed
    int m_seq [0:STEPS];      // LED value after k steps
    int m_leds = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    task automatic build_seq(input int x0, input int md);
        int x;
`ifdef LIGHT_DANCE_PINGPONG_EN
        int dir;
        dir = 0;
`endif
        x = x0;
        m_seq[0] = x;
        for (int k = 1; k <= STEPS; k++) begin
            case (md)
                0: x = (x * 2) % 256 + x / 128;
                1: x = x / 2 + (x % 2) * 128;
                2: x = (x * 2) % 256 + 1;
                default: begin
`ifdef LIGHT_DANCE_PINGPONG_EN
                    if (dir == 0) begin
                        if (x >= 128) begin dir = 1; x = x / 2; end
                        else x = (x * 2) % 256;
                    end else begin
                        if (x % 2 == 1) begin dir = 0; x = (x * 2) % 256; end
                        else x = x / 2;
                    end
`else
                    x = (x * 2) % 256 + x / 128;
`endif
                end
            endcase
            m_seq[k] = x;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_leds = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit t, input int md, input int sp, input int pat);
        case (m_phase)
            1: begin
                if (t) begin
                    m_phase = 0; m_leds = 0; m_busy = 1'b0;
                end else begin
                    m_n++;
                    if (m_n / (m_p + 1) >= STEPS) begin
                        m_phase = 2; m_leds = m_seq[STEPS]; m_busy = 1'b0; m_done = 1'b1;
                    end else begin
                        m_leds = m_seq[m_n / (m_p + 1)];
                    end
                end
            end
            2: begin
                m_phase = 0; m_done = 1'b0;
            end
            default: begin
                if (s && !t) begin
                    m_phase = 1; m_n = 0; m_p = sp;
                    build_seq(pat, md);
                    m_leds = pat; m_busy = 1'b1;
                end
            end
        endcase
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock edge: update model with sampled inputs, compare just after.
    task automatic cycle();
        @(posedge clk);
        if (!arst_n) model_reset();
        else model_edge(start, stop, int'(mode), int'(speed), int'(pattern));
        #1;
        check("leds", {24'd0, leds}, m_leds);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0] mode;
        logic [3:0] speed;
        logic [7:0] pattern;
        int         step;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [$];

    task automatic run_row(input vec_t v);
        int dn;
        dn = 0;
        mode = v.mode; speed = v.speed; pattern = v.pattern; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < STEPS * (int'(v.speed) + 1) + 3; c++) begin
            cycle();
            if (done === 1'b1) dn++;
            if (m_phase != 0 && m_n == v.step * (int'(v.speed) + 1))
                check("table_step", {24'd0, leds}, {24'd0, v.exp});
        end
        check("table_done_count", dn, 1);
    endtask

    initial begin
        int dn;
        logic [7:0] held;

        tbl.push_back('{2'b00, 4'd0, 8'h01,  1, 8'h02});
        tbl.push_back('{2'b00, 4'd0, 8'h01,  7, 8'h80});
        tbl.push_back('{2'b00, 4'd0, 8'h01, 16, 8'h01});
        tbl.push_back('{2'b10, 4'd3, 8'h00,  1, 8'h01});
        tbl.push_back('{2'b10, 4'd3, 8'h00,  3, 8'h07});
        tbl.push_back('{2'b10, 4'd3, 8'h00, 16, 8'hFF});
        tbl.push_back('{2'b01, 4'd1, 8'h80,  3, 8'h10});
        tbl.push_back('{2'b01, 4'd1, 8'h80,  8, 8'h80});
        tbl.push_back('{2'b11, 4'd0, 8'h40,  1, 8'h80});
`ifdef LIGHT_DANCE_PINGPONG_EN
        tbl.push_back('{2'b11, 4'd0, 8'h40,  2, 8'h40});
        tbl.push_back('{2'b11, 4'd0, 8'h40,  9, 8'h02});
`else
        tbl.push_back('{2'b11, 4'd0, 8'h40,  2, 8'h01});
        tbl.push_back('{2'b11, 4'd0, 8'h40,  9, 8'h80});
`endif

        // Reset state, then release; the first start must be taken at once.
        model_reset();
        cycle();
        cycle();
        arst_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i]);

        // Abort at step 5: leds cleared, busy low, no done pulse.
        mode = 2'b00; speed = 4'd0; pattern = 8'h01; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 40 && m_n < 5; c++) cycle();
        check("abort_at_step5", {24'd0, leds}, 32'h20);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("abort_leds", {24'd0, leds}, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        dn = 0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (done === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);

        // Start (with new settings) during RUN is ignored; settings stay latched.
        mode = 2'b00; speed = 4'd1; pattern = 8'h03; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        start = 1'b1; pattern = 8'hAA; mode = 2'b01; speed = 4'd0;
        cycle();
        cycle();
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (done === 1'b1) dn++;
        end
        check("ignore_done_count", dn, 1);
        check("ignore_final_leds", {24'd0, leds}, 32'h03);

        // start+stop together in IDLE: nothing happens.
        held = leds;
        start = 1'b1; stop = 1'b1; pattern = 8'h5A;
        cycle();
        cycle();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", {31'd0, busy}, 32'h0);
        check("startstop_leds", {24'd0, leds}, {24'd0, held});

        // Randomized runs with sporadic start/stop noise.
        for (int r = 0; r < 25; r++) begin
            int sp;
            sp = $urandom_range(0, 3);
            mode = 2'($urandom_range(0, 3)); speed = 4'(sp);
            pattern = 8'($urandom_range(0, 255)); start = 1'b1;
            cycle();
            start = 1'b0;
            for (int c = 0; c < STEPS * (sp + 1) + 3; c++) begin
                stop  = ($urandom_range(0, 149) == 0);
                start = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    mode = 2'($urandom_range(0, 3));
                    speed = 4'($urandom_range(0, 3));
                    pattern = 8'($urandom_range(0, 255));
                end
                cycle();
            end
            start = 1'b0; stop = 1'b0;
            cycle();
            cycle();
        end

        // Reset mid-run with the clock stopped.
        mode = 2'b00; speed = 4'd2; pattern = 8'h81; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
        @(negedge clk);
        #1 clk_en = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check("arst_leds", {24'd0, leds}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_done", {31'd0, done}, 32'h0);
        model_reset();
        #5 arst_n = 1'b1;
        #5 clk_en = 1'b1;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (done === 1'b1) dn++;
        end
        check("arst_no_done", dn, 0);
        mode = 2'b10; speed = 4'd0; pattern = 8'h00; start = 1'b1;
        cycle();
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < STEPS + 3; c++) begin
            cycle();
            if (done === 1'b1) dn++;
        end
        check("post_reset_done", dn, 1);
        check("post_reset_leds", {24'd0, leds}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
